// File: rtl/gpu_pkg.sv
// Shared constants, FSM state types and address helper for the GPU command sender.
package gpu_pkg;

    localparam int RESOLUTION_W   = 640;
    localparam int RESOLUTION_H   = 480;
    localparam int BITS_PER_PIXEL = 4;
    localparam int PACKET_BYTES   = 4;
    localparam int ADDR_W         = 19;
    localparam int X_W            = 10;
    localparam int Y_W            = 9;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_SEND
    } send_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Y*640 + X without a multiplier: 640 = 512 + 128.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [Y_W-1:0] y,
                                                     input logic [X_W-1:0] x);
        logic [ADDR_W-1:0] w_Y;
        w_Y = ADDR_W'(y);
        return (w_Y << 9) + (w_Y << 7) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/gpu_command_sender_if.sv
// Pixel-write request handshake between a host and the GPU command sender.
interface gpu_command_sender_if;
    import gpu_pkg::*;

    logic                      i_Cmd_Valid;
    logic                      o_Cmd_Ready;
    logic [X_W-1:0]            i_X;
    logic [Y_W-1:0]            i_Y;
    logic [BITS_PER_PIXEL-1:0] i_Color;

    modport master (
        output i_Cmd_Valid,
        output i_X,
        output i_Y,
        output i_Color,
        input  o_Cmd_Ready
    );

    modport slave (
        input  i_Cmd_Valid,
        input  i_X,
        input  i_Y,
        input  i_Color,
        output o_Cmd_Ready
    );

endinterface

// File: rtl/gpu_command_sender_uart_transmitter.sv
// 8N1 UART transmitter; a byte offered on the last stop-bit cycle starts immediately.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_Clock,
    input  logic       i_Reset_N,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);
    import gpu_pkg::*;

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        r_State;
    tx_state_t        w_Next_State;
    logic [CNT_W-1:0] r_Clk_Cnt;
    logic [2:0]       r_Bit_Idx;
    logic [7:0]       r_Data;
    logic             r_Tx;

    logic w_Bit_End;
    logic w_Next_Tx;
    logic w_Load;
    logic w_Shift;

    assign w_Bit_End = (r_Clk_Cnt == LAST_CNT);

    always_comb begin
        w_Next_State = r_State;
        w_Next_Tx    = r_Tx;
        w_Load       = 1'b0;
        w_Shift      = 1'b0;
        o_Tx_Done    = 1'b0;
        unique case (r_State)
            TX_IDLE: begin
                w_Next_Tx = 1'b1;
                if (i_Tx_DV) begin
                    w_Load       = 1'b1;
                    w_Next_Tx    = 1'b0;
                    w_Next_State = TX_START;
                end
            end
            TX_START: begin
                if (w_Bit_End) begin
                    w_Next_Tx    = r_Data[0];
                    w_Next_State = TX_DATA;
                end
            end
            TX_DATA: begin
                // r_Data[0] is always the bit on the line; shift to expose the next one.
                if (w_Bit_End) begin
                    if (r_Bit_Idx == 3'd7) begin
                        w_Next_Tx    = 1'b1;
                        w_Next_State = TX_STOP;
                    end else begin
                        w_Shift   = 1'b1;
                        w_Next_Tx = r_Data[1];
                    end
                end
            end
            TX_STOP: begin
                if (w_Bit_End) begin
                    o_Tx_Done = 1'b1;
                    if (i_Tx_DV) begin
                        w_Load       = 1'b1;
                        w_Next_Tx    = 1'b0;
                        w_Next_State = TX_START;
                    end else begin
                        w_Next_Tx    = 1'b1;
                        w_Next_State = TX_IDLE;
                    end
                end
            end
            default: begin
                w_Next_Tx    = 1'b1;
                w_Next_State = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            r_State   <= TX_IDLE;
            r_Tx      <= 1'b1;
            r_Clk_Cnt <= '0;
            r_Bit_Idx <= '0;
        end else begin
            r_State <= w_Next_State;
            r_Tx    <= w_Next_Tx;
            if (r_State == TX_IDLE || w_Bit_End) begin
                r_Clk_Cnt <= '0;
            end else begin
                r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
            end
            if (r_State != TX_DATA) begin
                r_Bit_Idx <= '0;
            end else if (w_Bit_End) begin
                r_Bit_Idx <= r_Bit_Idx + 3'd1;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_Load) begin
            r_Data <= i_Tx_Byte;
        end else if (w_Shift) begin
            r_Data <= {1'b0, r_Data[7:1]};
        end
    end

    assign o_Tx_Active = (r_State != TX_IDLE);
    assign o_Tx_Serial = r_Tx;

endmodule

// File: rtl/gpu_command_sender.sv
// Frames pixel-write requests as 4-byte packets (sync, addr lo, addr mid, colour|addr hi)
// and sends them over a UART line to the GPU.
module gpu_command_sender #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         RESOLUTION_W = gpu_pkg::RESOLUTION_W,
    parameter int         RESOLUTION_H = gpu_pkg::RESOLUTION_H,
    parameter logic [7:0] SYNC_BYTE    = gpu_pkg::SYNC_BYTE
) (
    input  logic     i_Clock,
    input  logic     i_Reset_N,
    gpu_command_sender_if.slave cmd,
    output logic     o_Uart_Tx,
    output logic     o_Busy,
    output logic     o_Range_Error
);
    import gpu_pkg::*;

    send_state_t               r_State;
    send_state_t               w_Next_State;
    logic                      r_Rst_Done;
    logic                      r_Range_Error;
    logic [1:0]                r_Byte_Idx;
    logic [X_W-1:0]            r_X;
    logic [Y_W-1:0]            r_Y;
    logic [BITS_PER_PIXEL-1:0] r_Color;
    logic [ADDR_W-1:0]         r_Addr;

    logic       w_Ready;
    logic       w_Accept;
    logic       w_In_Range;
    logic       w_Tx_DV;
    logic [7:0] w_Tx_Byte;
    logic       w_Tx_Done;
    logic       w_Tx_Active;
    logic       w_Tx_Serial;

    function automatic logic [7:0] packet_byte(input logic [1:0]                idx,
                                               input logic [ADDR_W-1:0]         addr,
                                               input logic [BITS_PER_PIXEL-1:0] color);
        unique case (idx)
            2'd0:    return SYNC_BYTE;
            2'd1:    return addr[7:0];
            2'd2:    return addr[15:8];
            default: return {color[3:0], 1'b0, addr[18:16]};
        endcase
    endfunction

    // Ready is held low until the first clock after reset is released.
    assign w_Ready         = (r_State == S_IDLE) && r_Rst_Done;
    assign w_Accept        = cmd.i_Cmd_Valid && w_Ready;
    assign w_In_Range      = (int'(cmd.i_X) < RESOLUTION_W) && (int'(cmd.i_Y) < RESOLUTION_H);
    assign cmd.o_Cmd_Ready = w_Ready;

    // The sync byte needs no address, so it is launched from ADDR while r_Addr loads.
    always_comb begin
        w_Next_State = r_State;
        w_Tx_DV      = 1'b0;
        w_Tx_Byte    = SYNC_BYTE;
        unique case (r_State)
            S_IDLE: begin
                if (w_Accept && w_In_Range) begin
                    w_Next_State = S_ADDR;
                end
            end
            S_ADDR: begin
                w_Tx_DV      = 1'b1;
                w_Tx_Byte    = packet_byte(2'd0, r_Addr, r_Color);
                w_Next_State = S_SEND;
            end
            S_SEND: begin
                if (w_Tx_Done) begin
                    if (r_Byte_Idx == 2'(PACKET_BYTES - 1)) begin
                        w_Next_State = S_IDLE;
                    end else begin
                        w_Tx_DV   = 1'b1;
                        w_Tx_Byte = packet_byte(r_Byte_Idx + 2'd1, r_Addr, r_Color);
                    end
                end
            end
            default: begin
                w_Next_State = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            r_State       <= S_IDLE;
            r_Rst_Done    <= 1'b0;
            r_Range_Error <= 1'b0;
            r_Byte_Idx    <= '0;
        end else begin
            r_State       <= w_Next_State;
            r_Rst_Done    <= 1'b1;
            r_Range_Error <= w_Accept && !w_In_Range;
            if (r_State == S_ADDR) begin
                r_Byte_Idx <= '0;
            end else if (r_State == S_SEND && w_Tx_Done) begin
                r_Byte_Idx <= r_Byte_Idx + 2'd1;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_Accept) begin
            r_X     <= cmd.i_X;
            r_Y     <= cmd.i_Y;
            r_Color <= cmd.i_Color;
        end
        if (r_State == S_ADDR) begin
            r_Addr <= pixel_addr(r_Y, r_X);
        end
    end

    uart_transmitter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .i_Clock    (i_Clock),
        .i_Reset_N  (i_Reset_N),
        .i_Tx_DV    (w_Tx_DV),
        .i_Tx_Byte  (w_Tx_Byte),
        .o_Tx_Active(w_Tx_Active),
        .o_Tx_Serial(w_Tx_Serial),
        .o_Tx_Done  (w_Tx_Done)
    );

    assign o_Uart_Tx     = w_Tx_Serial;
    assign o_Busy        = (r_State != S_IDLE) || w_Tx_Active;
    assign o_Range_Error = r_Range_Error;

endmodule

// File: tb/tb_gpu_command_sender.sv
// Directed and randomized bench for gpu_command_sender with a UART line decoder.
module tb_gpu_command_sender;

    localparam int CPB     = 4;
    localparam int BYTE_CY = 10 * CPB;
    localparam int PKT_CY  = 40 * CPB;
    localparam int RES_W   = 640;
    localparam int RES_H   = 480;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tx;
    logic busy;
    logic rerr;

    gpu_command_sender_if u_if();

    gpu_command_sender #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_Clock      (clk),
        .i_Reset_N    (rst_n),
        .cmd          (u_if),
        .o_Uart_Tx    (tx),
        .o_Busy       (busy),
        .o_Range_Error(rerr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference packet from plain arithmetic: {B3,B2,B1,B0}.
    function automatic logic [31:0] model_packet(input int x, input int y, input int c);
        int a;
        int b3;
        a  = y * RES_W + x;
        b3 = ((c & 15) * 16) + ((a / 65536) & 7);
        return {8'(b3), 8'((a / 256) & 255), 8'(a & 255), 8'hA5};
    endfunction

    // Line decoder: samples each bit at its centre, relying on exact bit timing.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    bit         dbusy = 0;
    int         dcnt  = 0;
    int         dstart = 0;
    logic [7:0] dbyte;

    always @(negedge clk) begin
        if (!rst_n) begin
            dbusy = 0;
        end else if (!dbusy) begin
            if (tx === 1'b0) begin
                dbusy  = 1;
                dcnt   = 0;
                dstart = cyc;
            end
        end else begin
            dcnt++;
        end
        if (dbusy && rst_n) begin
            if (dcnt == CPB / 2) begin
                chk("start_bit", 32'(tx), 32'd0);
            end else if (dcnt == 9 * CPB + CPB / 2) begin
                chk("stop_bit", 32'(tx), 32'd1);
                rx_q.push_back(dbyte);
                rx_t.push_back(dstart);
                dbusy = 0;
            end else if ((dcnt % CPB) == CPB / 2) begin
                dbyte[dcnt / CPB - 1] = tx;
            end
        end
    end

    task automatic wait_ready(input string tag);
        int t;
        t = 0;
        while (u_if.o_Cmd_Ready !== 1'b1 && t < 3 * PKT_CY) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3 * PKT_CY) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    // Present a request at a negedge; returns the cycle index of the handshake edge.
    task automatic issue(input string tag, input int x, input int y, input int c, output int hs);
        u_if.i_X         = 10'(x);
        u_if.i_Y         = 9'(y);
        u_if.i_Color     = 4'(c);
        u_if.i_Cmd_Valid = 1'b1;
        wait_ready(tag);
        @(negedge clk);
        hs = cyc;
    endtask

    task automatic check_packet(input string tag, input int x, input int y, input int c,
                                input int first_start);
        logic [31:0] pk;
        logic [7:0]  b;
        int          t;
        pk = model_packet(x, y, c);
        for (int i = 0; i < 4; i++) begin
            if (rx_q.size() == 0) begin
                chk($sformatf("%s_b%0d_missing", tag, i), 32'd0, 32'd1);
            end else begin
                b = rx_q.pop_front();
                t = rx_t.pop_front();
                chk($sformatf("%s_b%0d", tag, i), 32'(b), 32'(pk[8*i +: 8]));
                chk($sformatf("%s_b%0d_time", tag, i), 32'(t), 32'(first_start + i * BYTE_CY));
            end
        end
    endtask

    task automatic run_packet(input string tag, input int x, input int y, input int c);
        int hs;
        int low;
        issue(tag, x, y, c, hs);
        u_if.i_Cmd_Valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_ready_hs"}, 32'(u_if.o_Cmd_Ready), 32'd0);
        chk({tag, "_tx_addr"}, 32'(tx), 32'd1);
        low = 0;
        while (u_if.o_Cmd_Ready !== 1'b1 && low < 3 * PKT_CY) begin
            low++;
            @(negedge clk);
            if (low == 1) chk({tag, "_start_low"}, 32'(tx), 32'd0);
        end
        chk({tag, "_ready_low_cycles"}, 32'(low), 32'(1 + PKT_CY));
        check_packet(tag, x, y, c, hs + 1);
    endtask

    task automatic range_case(input string tag, input int x, input int y);
        bit bad;
        u_if.i_X         = 10'(x);
        u_if.i_Y         = 9'(y);
        u_if.i_Color     = 4'hA;
        u_if.i_Cmd_Valid = 1'b1;
        @(negedge clk);
        u_if.i_Cmd_Valid = 1'b0;
        chk({tag, "_pulse"}, 32'(rerr), 32'd1);
        chk({tag, "_ready"}, 32'(u_if.o_Cmd_Ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_pulse_end"}, 32'(rerr), 32'd0);
        bad = 0;
        repeat (3 * CPB) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || u_if.o_Cmd_Ready !== 1'b1) bad = 1;
        end
        chk({tag, "_line_quiet"}, 32'(bad), 32'd0);
        chk({tag, "_no_bytes"}, 32'(rx_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs1;
        int hs2;
        int xa, ya, ca, xb, yb, cb;

        u_if.i_Cmd_Valid = 1'b0;
        u_if.i_X         = '0;
        u_if.i_Y         = '0;
        u_if.i_Color     = '0;

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(u_if.o_Cmd_Ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rerr", 32'(rerr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(u_if.o_Cmd_Ready), 32'd1);

        run_packet("p_origin", 0, 0, 15);
        run_packet("p_corner", 639, 479, 3);
        run_packet("p_x100y1", 100, 1, 7);
        for (int i = 0; i < 4; i++) begin
            run_packet($sformatf("p_rand%0d", i), int'($urandom_range(0, RES_W - 1)),
                       int'($urandom_range(0, RES_H - 1)), int'($urandom_range(0, 15)));
        end

        range_case("rng_x640", 640, 0);
        range_case("rng_y480", 0, 480);
        range_case("rng_xrand", int'($urandom_range(RES_W, 1023)), int'($urandom_range(0, 511)));
        range_case("rng_yrand", int'($urandom_range(0, RES_W - 1)), int'($urandom_range(RES_H, 511)));

        // Valid held across two packets; second request's fields change mid first packet.
        xa = int'($urandom_range(0, RES_W - 1));
        ya = int'($urandom_range(0, RES_H - 1));
        ca = int'($urandom_range(0, 15));
        xb = int'($urandom_range(0, RES_W - 1));
        yb = int'($urandom_range(0, RES_H - 1));
        cb = int'($urandom_range(0, 15));
        issue("b2b_a", xa, ya, ca, hs1);
        u_if.i_X     = 10'(xb);
        u_if.i_Y     = 9'(yb);
        u_if.i_Color = 4'(cb);
        wait_ready("b2b_gap");
        @(negedge clk);
        hs2 = cyc;
        u_if.i_Cmd_Valid = 1'b0;
        chk("b2b_second_accept", 32'(hs2 - hs1), 32'(PKT_CY + 2));
        wait_ready("b2b_end");
        check_packet("b2b_a", xa, ya, ca, hs1 + 1);
        check_packet("b2b_b", xb, yb, cb, hs1 + 1 + PKT_CY + 2);

        // Reset asserted during B2.
        issue("rst_mid", 123, 45, 9, hs1);
        u_if.i_Cmd_Valid = 1'b0;
        repeat (1 + 2 * BYTE_CY + 5) @(negedge clk);
        chk("rst_mid_in_b2", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_tx", 32'(tx), 32'd1);
        chk("rst_mid_ready", 32'(u_if.o_Cmd_Ready), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_mid_ready_held", 32'(u_if.o_Cmd_Ready), 32'd0);
        chk("rst_mid_tx_held", 32'(tx), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready_rel", 32'(u_if.o_Cmd_Ready), 32'd1);
        rx_q.delete();
        rx_t.delete();
        run_packet("p_after_rst", int'($urandom_range(0, RES_W - 1)),
                   int'($urandom_range(0, RES_H - 1)), int'($urandom_range(0, 15)));

        repeat (4) @(negedge clk);
        chk("final_idle_tx", 32'(tx), 32'd1);
        chk("final_no_extra", 32'(rx_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
